// File: rtl/ex_wbck_arb_if.sv
// Write-back arbiter bus bundle: ALU result port, long-pipe result port,
// register-file write port and the dispatch hazard-check port.
interface ex_wbck_arb_if #(
    parameter int XLEN        = 32,
    parameter int RFIDX_W     = 5,
    parameter int LFIFO_DEPTH = 2
);
    localparam int CNT_W = $clog2(LFIFO_DEPTH) + 1;

    logic               alu_wbck_i_valid;
    logic               alu_wbck_i_ready;
    logic [RFIDX_W-1:0] alu_wbck_i_idx;
    logic [XLEN-1:0]    alu_wbck_i_wdat;

    logic               longp_wbck_i_valid;
    logic               longp_wbck_i_ready;
    logic [RFIDX_W-1:0] longp_wbck_i_idx;
    logic [XLEN-1:0]    longp_wbck_i_wdat;
    logic               longp_wbck_i_err;

    logic               rf_wbck_o_ena;
    logic [RFIDX_W-1:0] rf_wbck_o_idx;
    logic [XLEN-1:0]    rf_wbck_o_wdat;

    logic [RFIDX_W-1:0] chk_idx;
    logic               chk_hit;
    logic [CNT_W-1:0]   lfifo_cnt;

    // Producer side: ALU, long pipe and dispatch logic.
    modport master (
        output alu_wbck_i_valid, alu_wbck_i_idx, alu_wbck_i_wdat,
        input  alu_wbck_i_ready,
        output longp_wbck_i_valid, longp_wbck_i_idx, longp_wbck_i_wdat, longp_wbck_i_err,
        input  longp_wbck_i_ready,
        input  rf_wbck_o_ena, rf_wbck_o_idx, rf_wbck_o_wdat,
        output chk_idx,
        input  chk_hit, lfifo_cnt
    );

    // Arbiter side.
    modport slave (
        input  alu_wbck_i_valid, alu_wbck_i_idx, alu_wbck_i_wdat,
        output alu_wbck_i_ready,
        input  longp_wbck_i_valid, longp_wbck_i_idx, longp_wbck_i_wdat, longp_wbck_i_err,
        output longp_wbck_i_ready,
        output rf_wbck_o_ena, rf_wbck_o_idx, rf_wbck_o_wdat,
        input  chk_idx,
        output chk_hit, lfifo_cnt
    );
endinterface

// File: rtl/ex_wbck_arb.sv
// Write-back arbiter in front of the integer register-file write port.
// Single-cycle ALU results win by default. Long-pipe results queue in a small
// FIFO and are forced through after STARVE_MAX consecutive ALU wins.
module ex_wbck_arb #(
    parameter int XLEN        = 32,
    parameter int RFIDX_W     = 5,
    parameter int LFIFO_DEPTH = 2,
    parameter int STARVE_MAX  = 4
) (
    input logic          clk,
    input logic          rst_n,
    ex_wbck_arb_if.slave wb
);
    localparam int PTR_W = $clog2(LFIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    logic [RFIDX_W-1:0] idx_q  [LFIFO_DEPTH];
    logic [XLEN-1:0]    wdat_q [LFIFO_DEPTH];
    logic               err_q  [LFIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [STV_W-1:0] starve_q, starve_d;

    logic fifo_nonempty;
    logic lp_ready;
    logic push;
    logic pop;
    logic grant_lp;
    logic alu_ready;
    logic alu_fire;

    // Handshakes and the ALU-vs-FIFO grant decision.
    always_comb begin
        fifo_nonempty = (cnt_q != '0);
        lp_ready      = (cnt_q != CNT_W'(LFIFO_DEPTH));
        push          = wb.longp_wbck_i_valid & lp_ready;
        grant_lp      = fifo_nonempty &
                        (!wb.alu_wbck_i_valid | (starve_q == STV_W'(STARVE_MAX)));
        pop           = grant_lp;
        alu_ready     = !grant_lp;
        alu_fire      = wb.alu_wbck_i_valid & alu_ready;
    end

    // Pointer, occupancy and anti-starvation next-state.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        starve_d = starve_q;
        if (pop || !fifo_nonempty) begin
            starve_d = '0;
        end else if (alu_fire && (starve_q != STV_W'(STARVE_MAX))) begin
            starve_d = starve_q + STV_W'(1);
        end
    end

    // Control state; reset throws away anything still buffered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            starve_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
        end
    end

    // FIFO payload storage; validity is tracked by the occupancy count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            idx_q[wr_ptr_q]  <= wb.longp_wbck_i_idx;
            wdat_q[wr_ptr_q] <= wb.longp_wbck_i_wdat;
            err_q[wr_ptr_q]  <= wb.longp_wbck_i_err;
        end
    end

    // RF write port: x0 targets and faulted entries are consumed silently.
    always_comb begin
        wb.rf_wbck_o_ena  = 1'b0;
        wb.rf_wbck_o_idx  = '0;
        wb.rf_wbck_o_wdat = '0;
        if (pop) begin
            if (!err_q[rd_ptr_q] && (idx_q[rd_ptr_q] != '0)) begin
                wb.rf_wbck_o_ena  = 1'b1;
                wb.rf_wbck_o_idx  = idx_q[rd_ptr_q];
                wb.rf_wbck_o_wdat = wdat_q[rd_ptr_q];
            end
        end else if (alu_fire && (wb.alu_wbck_i_idx != '0)) begin
            wb.rf_wbck_o_ena  = 1'b1;
            wb.rf_wbck_o_idx  = wb.alu_wbck_i_idx;
            wb.rf_wbck_o_wdat = wb.alu_wbck_i_wdat;
        end
    end

    // Hazard check over stored entries only; the popping head still counts
    // because the RF takes its value at the same edge.
    logic [PTR_W-1:0] chk_off;
    logic             hit;
    always_comb begin
        chk_off = '0;
        hit     = 1'b0;
        for (int i = 0; i < LFIFO_DEPTH; i++) begin
            chk_off = PTR_W'(i) - rd_ptr_q;
            if (({1'b0, chk_off} < cnt_q) && !err_q[i] &&
                (idx_q[i] == wb.chk_idx) && (wb.chk_idx != '0)) begin
                hit = 1'b1;
            end
        end
    end

    // Remaining status outputs.
    always_comb begin
        wb.alu_wbck_i_ready   = alu_ready;
        wb.longp_wbck_i_ready = lp_ready;
        wb.chk_hit            = hit;
        wb.lfifo_cnt          = cnt_q;
    end
endmodule
